// File: rtl/vga_pkg.sv
// vga_pkg: nominal 640x480 VGA timing constants and shared receiver types.
package vga_pkg;
   localparam int HPIXELS = 800;
   localparam int VLINES  = 521;
   localparam int HPULSE  = 96;
   localparam int VPULSE  = 2;
   localparam int HBP     = 144;
   localparam int HFP     = 784;
   localparam int VBP     = 31;
   localparam int VFP     = 511;
   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} rx_state_t;
   typedef logic [11:0] rgb12_t;
endpackage

// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: VGA pixel input plus recovered active-area outputs.
interface vga_timing_rx_if;
   import vga_pkg::*;
   logic       pix_en, hsync_in, vsync_in;
   rgb12_t     rgb_in, pixel;
   logic [9:0] x, y;
   logic       de, locked, frame_start, err;
   modport master (output pix_en, hsync_in, vsync_in, rgb_in,
                   input x, y, de, pixel, locked, frame_start, err);
   modport slave  (input pix_en, hsync_in, vsync_in, rgb_in,
                   output x, y, de, pixel, locked, frame_start, err);
endinterface

// File: rtl/sync_fall.sv
// sync_fall: input register chain and pix_en-qualified previous sample flagging a falling edge.
// VGA_RX_SYNC_EN selects a 2-flop synchronizer instead of a single register.
module sync_fall (
   input  logic clk,
   input  logic rst_n,
   input  logic pix_en_i,
   input  logic d_i,
   output logic fall_o
);
   logic cur, prev_q;
`ifdef VGA_RX_SYNC_EN
   logic [1:0] s_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s_q <= '1;
      else s_q <= {s_q[0], d_i};
   assign cur = s_q[1];
`else
   logic s_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s_q <= 1'b1;
      else s_q <= d_i;
   assign cur = s_q;
`endif
   // Idle-high reset so releasing reset never looks like a sync edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prev_q <= 1'b1;
      else if (pix_en_i) prev_q <= cur;
   assign fall_o = prev_q & ~cur;
endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: VGA receiver recovering h/v counters, locking on nominal timing, emitting active pixels.
// VGA_RX_SYNC_EN adds a 2-flop synchronizer on sync and RGB inputs for asynchronous sources.
module vga_timing_rx #(
   parameter int HPIXELS     = vga_pkg::HPIXELS,
   parameter int VLINES      = vga_pkg::VLINES,
   parameter int HBP         = vga_pkg::HBP,
   parameter int HFP         = vga_pkg::HFP,
   parameter int VBP         = vga_pkg::VBP,
   parameter int VFP         = vga_pkg::VFP,
   parameter int LOCK_FRAMES = 2
) (
   input logic            clk,
   input logic            btnCpuReset,
   vga_timing_rx_if.slave bus
);
   vga_pkg::rx_state_t state_q, state_d;
   vga_pkg::rgb12_t    rgb_q;
   logic [9:0] hc_q, hc_d, vc_q, vc_d, hc_sat, vc_sat;
   logic [2:0] good_q, good_d;
   logic       h_fall, v_fall, viol, de_d;

   sync_fall u_hs (.clk, .rst_n(btnCpuReset), .pix_en_i(bus.pix_en), .d_i(bus.hsync_in), .fall_o(h_fall));
   sync_fall u_vs (.clk, .rst_n(btnCpuReset), .pix_en_i(bus.pix_en), .d_i(bus.vsync_in), .fall_o(v_fall));

`ifdef VGA_RX_SYNC_EN
   vga_pkg::rgb12_t rgb_m_q;
   always_ff @(posedge clk or negedge btnCpuReset)
      if (!btnCpuReset) {rgb_m_q, rgb_q} <= '0;
      else {rgb_m_q, rgb_q} <= {bus.rgb_in, rgb_m_q};
`else
   always_ff @(posedge clk or negedge btnCpuReset)
      if (!btnCpuReset) rgb_q <= '0;
      else rgb_q <= bus.rgb_in;
`endif

   always_comb begin
      hc_sat  = hc_q + {9'd0, hc_q != 10'd1023};
      vc_sat  = vc_q + {9'd0, vc_q != 10'd1023};
      hc_d    = h_fall ? '0 : hc_sat;
      vc_d    = v_fall ? '0 : h_fall ? vc_sat : vc_q;
      viol    = (h_fall && int'(hc_q) + 1 != HPIXELS) ||
                (v_fall && (!h_fall || int'(vc_q) + 1 != VLINES)) || &hc_d || &vc_d;
      good_d  = state_q != vga_pkg::MEASURE ? '0 : v_fall && !viol ? good_q + 3'd1 : good_q;
      state_d = state_q == vga_pkg::SEARCH ? (v_fall ? vga_pkg::MEASURE : vga_pkg::SEARCH)
              : viol ? vga_pkg::SEARCH
              : state_q == vga_pkg::MEASURE && int'(good_d) == LOCK_FRAMES ? vga_pkg::LOCKED
              : state_q;
      de_d    = state_d == vga_pkg::LOCKED && int'(hc_d) >= HBP && int'(hc_d) < HFP &&
                int'(vc_d) >= VBP && int'(vc_d) < VFP;
   end

   // Pulses last one clk; everything else only moves on a pixel strobe
   always_ff @(posedge clk or negedge btnCpuReset)
      if (!btnCpuReset) begin
         state_q         <= vga_pkg::SEARCH;
         hc_q            <= '0;
         vc_q            <= '0;
         good_q          <= '0;
         bus.x           <= '0;
         bus.y           <= '0;
         bus.de          <= 1'b0;
         bus.pixel       <= '0;
         bus.locked      <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.err         <= 1'b0;
      end else begin
         bus.frame_start <= bus.pix_en && state_d == vga_pkg::LOCKED && v_fall && !viol;
         bus.err         <= bus.pix_en && state_q == vga_pkg::LOCKED && viol;
         if (bus.pix_en) begin
            state_q    <= state_d;
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            good_q     <= good_d;
            bus.de     <= de_d;
            bus.x      <= de_d ? hc_d - 10'(HBP) : '0;
            bus.y      <= de_d ? vc_d - 10'(VBP) : '0;
            bus.pixel  <= de_d ? rgb_q : '0;
            bus.locked <= state_d == vga_pkg::LOCKED;
         end
      end
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed checks of lock, active-area mapping, timing violations and reset
// on a scaled-down 20x12 raster (active hc 5..14, vc 3..9), pixel strobe every 4 clk.
module tb_vga_timing_rx;
   localparam int HP = 20, VL = 12, HB = 5, HF = 15, VB = 3, VF = 10;
   logic clk = 1'b0, rst_n = 1'b0;
   int   tests = 0, fails = 0;
   int   ghc = 0, gvc = 0, hlen = HP, vlen = VL, lh = 0, lv = 0, errs_seen = 0, fs_seen = 0;
   bit   hold = 1'b0;

   vga_timing_rx_if bus();
   vga_timing_rx #(.HPIXELS(HP), .VLINES(VL), .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(2))
      dut (.clk(clk), .btnCpuReset(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [11:0] rgb_of(int h, int v);
      return {4'(v), 8'(h)};
   endfunction

   function automatic logic [35:0] outs();
      return {bus.de, bus.locked, bus.frame_start, bus.err, bus.x, bus.y, bus.pixel};
   endfunction

   // Present one pixel 3 clk ahead of its strobe; returns at a negedge after the output update
   task automatic emit();
      bus.hsync_in = hold || ghc >= 2;
      bus.vsync_in = hold || gvc >= 2;
      bus.rgb_in   = rgb_of(ghc, gvc);
      lh = ghc;
      lv = gvc;
      repeat (3) @(negedge clk);
      bus.pix_en = 1'b1;
      @(negedge clk);
      bus.pix_en = 1'b0;
      errs_seen += int'(bus.err);
      fs_seen   += int'(bus.frame_start);
      ghc++;
      if (ghc >= hlen) begin
         ghc = 0;
         gvc++;
         if (gvc >= vlen) gvc = 0;
      end
   endtask

   task automatic emit_to(int h, int v);
      do emit(); while (!(lh == h && lv == v));
   endtask

   task automatic to_fall();
      emit_to(0, 0);
   endtask

   task automatic test_reset();
      int bad = 0;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (outs() !== '0) begin fails++; $display("FAIL reset_state: outputs=%h required 0", outs()); end
      rst_n = 1'b1;
      hold  = 1'b1;
      repeat (250) begin
         emit();
         if (outs() !== '0) bad++;
      end
      hold = 1'b0;
      ghc  = 0;
      gvc  = 0;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL idle_outputs: %0d nonzero samples required 0", bad); end
   endtask

   task automatic test_lock();
      to_fall();
      tests++;
      if (bus.locked !== 1'b0) begin fails++; $display("FAIL lock_fall1: locked=%b required 0", bus.locked); end
      to_fall();
      tests++;
      if (bus.locked !== 1'b0 || bus.frame_start !== 1'b0) begin
         fails++; $display("FAIL lock_fall2: locked=%b fs=%b required 0 0", bus.locked, bus.frame_start);
      end
      to_fall();
      tests++;
      if (bus.locked !== 1'b1) begin fails++; $display("FAIL lock_fall3: locked=%b required 1", bus.locked); end
      tests++;
      if (bus.frame_start !== 1'b1) begin fails++; $display("FAIL lock_fs: frame_start=%b required 1", bus.frame_start); end
   endtask

   task automatic test_active();
      emit_to(HB - 1, VB);
      tests++;
      if (bus.de !== 1'b0) begin fails++; $display("FAIL pre_active: de=%b required 0", bus.de); end
      emit();
      tests++;
      if ({bus.de, bus.x, bus.y, bus.pixel} !== {1'b1, 10'd0, 10'd0, 12'h305}) begin
         fails++; $display("FAIL first_pixel: de=%b x=%0d y=%0d pixel=%h required 1 0 0 305", bus.de, bus.x, bus.y, bus.pixel);
      end
      repeat (12) @(negedge clk);
      tests++;
      if ({bus.de, bus.x, bus.pixel} !== {1'b1, 10'd0, 12'h305}) begin
         fails++; $display("FAIL strobe_gap: de=%b x=%0d pixel=%h required 1 0 305", bus.de, bus.x, bus.pixel);
      end
      emit();
      tests++;
      if (bus.x !== 10'd1) begin fails++; $display("FAIL second_pixel: x=%0d required 1", bus.x); end
      emit_to(HF - 1, VF - 1);
      tests++;
      if ({bus.de, bus.x, bus.y, bus.pixel} !== {1'b1, 10'd9, 10'd6, 12'h90E}) begin
         fails++; $display("FAIL last_pixel: de=%b x=%0d y=%0d pixel=%h required 1 9 6 90e", bus.de, bus.x, bus.y, bus.pixel);
      end
      emit();
      tests++;
      if ({bus.de, bus.x, bus.y, bus.pixel} !== '0) begin
         fails++; $display("FAIL post_active: de=%b x=%0d y=%0d pixel=%h required all 0", bus.de, bus.x, bus.y, bus.pixel);
      end
   endtask

   task automatic test_stretch();
      int e0;
      emit_to(0, 5);
      hlen = HP + 1;
      emit_to(HP, 5);
      hlen = HP;
      e0 = errs_seen;
      tests++;
      if (bus.locked !== 1'b1) begin fails++; $display("FAIL stretch_pre: locked=%b required 1", bus.locked); end
      emit();
      tests++;
      if (bus.err !== 1'b1 || bus.locked !== 1'b0) begin
         fails++; $display("FAIL stretch_err: err=%b locked=%b required 1 0", bus.err, bus.locked);
      end
      @(negedge clk);
      tests++;
      if (bus.err !== 1'b0) begin fails++; $display("FAIL err_width: err=%b required 0", bus.err); end
      to_fall();
      to_fall();
      tests++;
      if (bus.locked !== 1'b0) begin fails++; $display("FAIL stretch_early_lock: locked=%b required 0", bus.locked); end
      to_fall();
      tests++;
      if (bus.locked !== 1'b1 || errs_seen - e0 != 1) begin
         fails++; $display("FAIL stretch_relock: locked=%b errs=%0d required 1 1", bus.locked, errs_seen - e0);
      end
   endtask

   task automatic test_hold_hsync();
      int e0;
      e0   = errs_seen;
      hold = 1'b1;
      repeat (1022) emit();
      tests++;
      if (bus.locked !== 1'b1 || errs_seen != e0) begin
         fails++; $display("FAIL hold_pre: locked=%b errs=%0d required 1 0", bus.locked, errs_seen - e0);
      end
      emit();
      tests++;
      if (bus.err !== 1'b1 || bus.locked !== 1'b0) begin
         fails++; $display("FAIL hold_err: err=%b locked=%b required 1 0", bus.err, bus.locked);
      end
      repeat (20) emit();
      hold = 1'b0;
      tests++;
      if (bus.locked !== 1'b0 || errs_seen - e0 != 1) begin
         fails++; $display("FAIL hold_search: locked=%b errs=%0d required 0 1", bus.locked, errs_seen - e0);
      end
   endtask

   task automatic test_short_frame();
      int e0;
      to_fall();
      vlen = VL - 1;
      e0   = errs_seen;
      to_fall();
      vlen = VL;
      tests++;
      if (bus.locked !== 1'b0 || errs_seen != e0) begin
         fails++; $display("FAIL short_frame: locked=%b errs=%0d required 0 0", bus.locked, errs_seen - e0);
      end
      to_fall();
      to_fall();
      tests++;
      if (bus.locked !== 1'b0) begin fails++; $display("FAIL short_restart: locked=%b required 0", bus.locked); end
      to_fall();
      tests++;
      if (bus.locked !== 1'b1 || bus.frame_start !== 1'b1) begin
         fails++; $display("FAIL short_relock: locked=%b fs=%b required 1 1", bus.locked, bus.frame_start);
      end
   endtask

   task automatic test_reset_mid();
      int fs0;
      emit_to(HB + 2, VB + 1);
      tests++;
      if ({bus.de, bus.x, bus.y, bus.pixel} !== {1'b1, 10'd2, 10'd1, 12'h407}) begin
         fails++; $display("FAIL mid_pixel: de=%b x=%0d y=%0d pixel=%h required 1 2 1 407", bus.de, bus.x, bus.y, bus.pixel);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (outs() !== '0) begin fails++; $display("FAIL reset_mid_clear: outputs=%h required 0", outs()); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      fs0   = fs_seen;
      to_fall();
      to_fall();
      tests++;
      if (fs_seen != fs0 || bus.locked !== 1'b0) begin
         fails++; $display("FAIL reset_mid_nofs: fs=%0d locked=%b required 0 0", fs_seen - fs0, bus.locked);
      end
      to_fall();
      tests++;
      if (bus.frame_start !== 1'b1 || bus.locked !== 1'b1) begin
         fails++; $display("FAIL reset_mid_relock: fs=%b locked=%b required 1 1", bus.frame_start, bus.locked);
      end
   endtask

   initial begin
      bus.pix_en   = 1'b0;
      bus.hsync_in = 1'b1;
      bus.vsync_in = 1'b1;
      bus.rgb_in   = '0;
      test_reset();
      test_lock();
      test_active();
      test_stretch();
      test_hold_hsync();
      test_short_frame();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
